// File: rtl/wide_add_seq.sv
// Multi-cycle wide adder: {cout,s} = a + b + cin on W*N-bit operands,
// computed with a single W-bit adder slice reused for N passes, LSB slice
// first, with the inter-slice carry held in a register.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_valid/in_ready   operand handshake (in_ready high only in IDLE)
//   a, b, cin           operands and carry-in, sampled at the accept edge
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   s, cout             registered sum and carry-out, held while in DONE
module wide_add_seq #(
  parameter int unsigned W = 16,
  parameter int unsigned N = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [W*N-1:0]  a,
  input  logic [W*N-1:0]  b,
  input  logic            cin,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W*N-1:0]  s,
  output logic            cout
);

  localparam int unsigned XW = W * N;
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   a_q, a_d;
  logic [XW-1:0]   b_q, b_d;
  logic [XW-1:0]   s_q, s_d;
  logic            carry_q, carry_d;
  logic            cout_q, cout_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;

  // Slice datapath for the current pass
  logic [31:0]     slice_sh;
  logic [W-1:0]    slice_a;
  logic [W-1:0]    slice_b;
  logic [W-1:0]    slice_sum;
  logic            slice_c;
  logic [XW-1:0]   slice_mask;

  // Select the active slice, add it with the running carry, and build the
  // write mask that places the slice sum back into s.
  always_comb begin
    slice_sh   = 32'(idx_q) * W;
    slice_a    = W'(a_q >> slice_sh);
    slice_b    = W'(b_q >> slice_sh);
    {slice_c, slice_sum} = (W+1)'(slice_a) + (W+1)'(slice_b) + (W+1)'(carry_q);
    slice_mask = XW'({W{1'b1}}) << slice_sh;
  end

  // Next-state and next-output logic
  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    s_d         = s_q;
    carry_d     = carry_q;
    cout_d      = cout_q;
    idx_d       = idx_q;

    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        // Only the active slice of s is rewritten; upper slices keep their
        // old contents until their own pass.
        s_d     = (s_q & ~slice_mask) | (XW'(slice_sum) << slice_sh);
        carry_d = slice_c;
        idx_d   = idx_q + IW'(1);
        if (idx_q == LAST_IDX) begin
          cout_d  = slice_c;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered copies of the next state decode.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      s_q         <= '0;
      carry_q     <= 1'b0;
      cout_q      <= 1'b0;
      idx_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      s_q         <= s_d;
      carry_q     <= carry_d;
      cout_q      <= cout_d;
      idx_q       <= idx_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign s         = s_q;
  assign cout      = cout_q;

endmodule

// File: tb/tb_wide_add_seq.sv
// Self-checking bench for wide_add_seq: directed vector table, hand-written
// corner sequences (backpressure, held in_valid, mid-run reset) and a
// randomized sweep, on a W=16/N=4 instance (d=0) and a W=64/N=1 instance (d=1).
module tb_wide_add_seq;

  logic        clk;
  logic        rst_n;
  logic        iv   [2];
  logic        ir   [2];
  logic [63:0] av   [2];
  logic [63:0] bv   [2];
  logic        ci   [2];
  logic        ov   [2];
  logic        ordy [2];
  logic [63:0] sv   [2];
  logic        co   [2];

  int n_vec;
  int n_mis;

  wide_add_seq #(.W(16), .N(4)) u_n4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[0]), .in_ready(ir[0]),
    .a(av[0]), .b(bv[0]), .cin(ci[0]),
    .out_valid(ov[0]), .out_ready(ordy[0]),
    .s(sv[0]), .cout(co[0])
  );

  wide_add_seq #(.W(64), .N(1)) u_n1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(iv[1]), .in_ready(ir[1]),
    .a(av[1]), .b(bv[1]), .cin(ci[1]),
    .out_valid(ov[1]), .out_ready(ordy[1]),
    .s(sv[1]), .cout(co[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    int          stall;
    logic [63:0] exp_s;
    logic        exp_cout;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string nm, input logic [64:0] act, input logic [64:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full transaction on instance d; 'hold' keeps in_valid high and
  // scrambles the operands while the operation is in flight.
  task automatic txn(input int d, input logic [63:0] ta, input logic [63:0] tb_,
                     input logic tc, input int stall, input bit hold,
                     input logic [64:0] exp, input string nm);
    int cnt;
    int lat;
    lat = (d == 0) ? 4 : 1;
    cnt = 0;
    while (!ir[d] && cnt < 100) begin
      tick();
      cnt++;
    end
    chk($sformatf("%s[%0d] ready_before", nm, d), 65'(ir[d]), 65'(1));
    av[d]   = ta;
    bv[d]   = tb_;
    ci[d]   = tc;
    iv[d]   = 1'b1;
    ordy[d] = 1'b0;
    tick();
    av[d] = ~ta;
    bv[d] = ~tb_;
    ci[d] = ~tc;
    if (!hold) iv[d] = 1'b0;
    else chk($sformatf("%s[%0d] ready_busy", nm, d), 65'(ir[d]), 65'(0));
    cnt = 0;
    while (!ov[d] && cnt < 100) begin
      if (hold) begin
        av[d] = {$urandom, $urandom};
        bv[d] = {$urandom, $urandom};
      end
      tick();
      cnt++;
    end
    chk($sformatf("%s[%0d] latency", nm, d), 65'(cnt), 65'(lat));
    for (int i = 0; i < stall; i++) begin
      tick();
      chk($sformatf("%s[%0d] stall_valid", nm, d), {63'(0), ov[d], ir[d]}, 65'b10);
      chk($sformatf("%s[%0d] stall_hold", nm, d), {co[d], sv[d]}, exp);
    end
    chk($sformatf("%s[%0d] result", nm, d), {co[d], sv[d]}, exp);
    ordy[d] = 1'b1;
    tick();
    ordy[d] = 1'b0;
    iv[d]   = 1'b0;
    chk($sformatf("%s[%0d] release", nm, d), {63'(0), ov[d], ir[d]}, 65'b01);
  endtask

  initial begin
    logic [63:0] ra, rb;
    logic        rc;
    n_vec = 0;
    n_mis = 0;

    vecs[0] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 0, 64'h0, 1'b1};
    vecs[1] = '{64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 1, 64'h0001_0000_0001_0000, 1'b0};
    vecs[2] = '{64'h0, 64'h0, 1'b0, 0, 64'h0, 1'b0};
    vecs[3] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 2, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1};
    vecs[4] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 0, 64'h0, 1'b1};
    vecs[5] = '{64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1, 64'h2222_2222_2222_2211, 1'b0};
    vecs[6] = '{64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 0, 64'h0000_0000_0001_0000, 1'b0};
    vecs[7] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 3, 64'h8000_0000_0000_0000, 1'b0};

    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; ordy[d] = 1'b0; av[d] = '0; bv[d] = '0; ci[d] = 1'b0;
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("reset[%0d] handshake", d), {63'(0), ov[d], ir[d]}, 65'b01);
      chk($sformatf("reset[%0d] result", d), {co[d], sv[d]}, 65'(0));
    end

    // Directed table on both instances
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 8; i++) begin
        txn(d, vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall, 1'b0,
            {vecs[i].exp_cout, vecs[i].exp_s}, $sformatf("vec%0d", i));
      end
    end

    // Backpressure: six stalled cycles in DONE
    txn(0, 64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 6, 1'b0,
        {1'b0, 64'h0001_0000_0001_0000}, "backpressure");

    // in_valid held through RUN/DONE with changing operands
    txn(0, 64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 2, 1'b1,
        {1'b0, 64'h2222_2222_2222_2211}, "hold_valid");
    tick();
    chk("hold_valid single_txn", {63'(0), ov[0], ir[0]}, 65'b01);

    // Reset in mid-RUN with idx=2
    av[0] = 64'hFFFF_FFFF_FFFF_FFFF; bv[0] = 64'h0; ci[0] = 1'b1; iv[0] = 1'b1;
    tick();
    iv[0] = 1'b0;
    tick();
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrun_reset handshake", {63'(0), ov[0], ir[0]}, 65'b01);
    chk("midrun_reset result", {co[0], sv[0]}, 65'(0));
    tick();
    chk("midrun_reset stays_idle", {63'(0), ov[0], ir[0]}, 65'b01);
    txn(0, 64'h0000_0000_0000_FFFF, 64'h0, 1'b1, 0, 1'b0,
        {1'b0, 64'h0000_0000_0001_0000}, "after_reset");

    // Randomized sweep against a+b+cin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < 1000; i++) begin
        ra = {$urandom, $urandom};
        rb = {$urandom, $urandom};
        rc = 1'($urandom_range(0, 1));
        txn(d, ra, rb, rc, int'($urandom_range(0, 3)), 1'b0,
            65'(ra) + 65'(rb) + 65'(rc), "rand");
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
